multicycle_controller: RTL and testbench

Main control unit for the multicycle RV32I core. Each cycle it drives the shared datapath's muxes and enables, the ALU operation, and the immediate-format select for the immediate extension unit. It sequences every instruction through fetch, decode, execute, memory and writeback states, and stalls on a ready/request memory handshake. Its inputs are the instruction register and the ALU flags; it holds no datapath registers of its own.

---
 rtl/riscv_pkg.sv | 64 ++++++
 rtl/alu_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 217 +++++++++++++++++++++
 tb/tb_multicycle_controller.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds opcode constants, the immediate-format codes used by the immediate
// extension unit, ALU operation codes, datapath mux selects and the FSM
// state type. No ports.
package riscv_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_OPIMM  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLTU = 4'b0110;
    localparam logic [3:0] ALU_SLL  = 4'b0111;
    localparam logic [3:0] ALU_SRL  = 4'b1000;
    localparam logic [3:0] ALU_SRA  = 4'b1001;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;
    localparam logic [1:0] SRCA_ZERO  = 2'b11;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT  = 2'b00;
    localparam logic [1:0] RES_MEMDATA = 2'b01;
    localparam logic [1:0] RES_ALU     = 2'b10;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH, S_JAL, S_JALR,
        S_JALR_PC, S_LUI, S_AUIPC
    } state_t;

    function automatic logic [2:0] imm_src_of(input logic [6:0] opcode);
        case (opcode)
            OP_LOAD, OP_OPIMM, OP_JALR: imm_src_of = IMM_I;
            OP_STORE:                   imm_src_of = IMM_S;
            OP_BRANCH:                  imm_src_of = IMM_B;
            OP_JAL:                     imm_src_of = IMM_J;
            OP_LUI, OP_AUIPC:           imm_src_of = IMM_U;
            default:                    imm_src_of = 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decode for register and immediate ALU ops.
// Ports:
//   is_rtype    in  1  instruction is OP (register-register); else OP-IMM
//   funct3      in  3  instr[14:12]
//   funct7b5    in  1  instr[30]
//   alu_control out 4  ALU operation code
module alu_decoder
    import riscv_pkg::*;
(
    input  logic       is_rtype,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    output logic [3:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (funct3)
            // instr[30] of ADDI is an immediate bit, so only OP may subtract
            3'b000: alu_control = (is_rtype && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001: alu_control = ALU_SLL;
            3'b010: alu_control = ALU_SLT;
            3'b011: alu_control = ALU_SLTU;
            3'b100: alu_control = ALU_XOR;
            // shifts carry the arithmetic flag in both forms (SRA / SRAI)
            3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110: alu_control = ALU_OR;
            3'b111: alu_control = ALU_AND;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core. Drives datapath muxes,
// enables, ALU operation and immediate format each cycle; stalls on the
// mem_req/mem_ready handshake. All outputs are forced low while rst=1.
// Ports:
//   clk, rst (sync, active high); instr; alu_zero/alu_lt/alu_ltu flags;
//   mem_ready; mem_req, mem_write, adr_src; ir_write, pc_write, reg_write;
//   alu_src_a, alu_src_b, result_src, alu_control, imm_src; illegal_instr.
//
// state      | meaning
// FETCH      | request instr at PC; on ready load IR, PC <= PC+4
// DECODE     | ALUOut <= old_pc+imm (branch/JAL target); dispatch on opcode
// MEMADR     | ALUOut <= rs1+imm
// MEMREAD    | read at ALUOut, wait for ready
// MEMWB      | rd <= memory data
// MEMWRITE   | write at ALUOut, wait for ready
// EXECUTER   | ALUOut <= rs1 op rs2
// EXECUTEI   | ALUOut <= rs1 op imm
// ALUWB      | rd <= ALUOut
// BRANCH     | compare rs1/rs2; PC <= ALUOut when taken
// JAL        | PC <= ALUOut, ALUOut <= old_pc+4
// JALR       | ALUOut <= rs1+imm
// JALR_PC    | PC <= ALUOut, ALUOut <= old_pc+4
// LUI        | ALUOut <= 0+imm
// AUIPC      | ALUOut <= old_pc+imm
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        alu_zero,
    input  logic        alu_lt,
    input  logic        alu_ltu,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_write,
    output logic        adr_src,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [3:0]  alu_control,
    output logic [2:0]  imm_src,
    output logic        illegal_instr
);

    state_t      state, state_next;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [3:0]  alu_dec;
    logic        taken, branch_bad;
    logic        unused_instr;

    assign opcode       = instr[6:0];
    assign funct3       = instr[14:12];
    assign unused_instr = ^{instr[31], instr[29:15], instr[11:7]};

    alu_decoder u_alu_decoder (
        .is_rtype    (opcode == OP_OP),
        .funct3      (funct3),
        .funct7b5    (instr[30]),
        .alu_control (alu_dec)
    );

    always_comb begin
        taken      = 1'b0;
        branch_bad = 1'b0;
        case (funct3)
            3'b000:  taken = alu_zero;
            3'b001:  taken = !alu_zero;
            3'b100:  taken = alu_lt;
            3'b101:  taken = !alu_lt;
            3'b110:  taken = alu_ltu;
            3'b111:  taken = !alu_ltu;
            default: branch_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= S_FETCH;
        else     state <= state_next;
    end

    always_comb begin
        state_next    = state;
        mem_req       = 1'b0;
        mem_write     = 1'b0;
        adr_src       = 1'b0;
        ir_write      = 1'b0;
        pc_write      = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = SRCA_PC;
        alu_src_b     = SRCB_RS2;
        result_src    = RES_ALUOUT;
        alu_control   = ALU_ADD;
        imm_src       = imm_src_of(opcode);
        illegal_instr = 1'b0;

        case (state)
            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    alu_src_a  = SRCA_PC;
                    alu_src_b  = SRCB_FOUR;
                    result_src = RES_ALU;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_a = SRCA_OLDPC;
                alu_src_b = SRCB_IMM;
                case (opcode)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_OP:             state_next = S_EXECUTER;
                    OP_OPIMM:          state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BRANCH;
                    OP_JAL:            state_next = S_JAL;
                    OP_JALR:           state_next = S_JALR;
                    OP_LUI:            state_next = S_LUI;
                    OP_AUIPC:          state_next = S_AUIPC;
                    default: begin
                        illegal_instr = 1'b1;
                        state_next    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = (opcode == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = RES_MEMDATA;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) state_next = S_FETCH;
            end
            S_EXECUTER: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_RS2;
                alu_control = alu_dec;
                state_next  = S_ALUWB;
            end
            S_EXECUTEI: begin
                alu_src_a   = SRCA_RS1;
                alu_src_b   = SRCB_IMM;
                alu_control = alu_dec;
                state_next  = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a     = SRCA_RS1;
                alu_src_b     = SRCB_RS2;
                alu_control   = ALU_SUB;
                pc_write      = taken;
                illegal_instr = branch_bad;
                state_next    = S_FETCH;
            end
            S_JAL, S_JALR_PC: begin
                pc_write   = 1'b1;
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_FOUR;
                state_next = S_ALUWB;
            end
            S_JALR: begin
                alu_src_a  = SRCA_RS1;
                alu_src_b  = SRCB_IMM;
                state_next = S_JALR_PC;
            end
            S_LUI: begin
                alu_src_a  = SRCA_ZERO;
                alu_src_b  = SRCB_IMM;
                state_next = S_ALUWB;
            end
            S_AUIPC: begin
                alu_src_a  = SRCA_OLDPC;
                alu_src_b  = SRCB_IMM;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase

        // reset silences the datapath immediately, including a pending request
        if (rst) begin
            mem_req       = 1'b0;
            mem_write     = 1'b0;
            adr_src       = 1'b0;
            ir_write      = 1'b0;
            pc_write      = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 2'b00;
            alu_src_b     = 2'b00;
            result_src    = 2'b00;
            alu_control   = 4'b0000;
            imm_src       = 3'b000;
            illegal_instr = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. The model turns each
// instruction into the list of control steps it must produce, and one
// compare process checks all outputs against the current step every cycle.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] instr = 32'h0;
    logic        alu_zero = 1'b0, alu_lt = 1'b0, alu_ltu = 1'b0;
    logic        mem_ready = 1'b0;
    logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
    logic [1:0]  alu_src_a, alu_src_b, result_src;
    logic [3:0]  alu_control;
    logic [2:0]  imm_src;
    logic        illegal_instr;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .instr(instr),
        .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write),
        .adr_src(adr_src), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .result_src(result_src), .alu_control(alu_control),
        .imm_src(imm_src), .illegal_instr(illegal_instr)
    );

    always #5 clk = ~clk;

    // control vector: {req,wr,adr,irw,pcw,rw,a[2],b[2],res[2],alu[4],imm[3],ill}
    typedef struct {
        string       name;
        bit          is_wait;
        logic [19:0] ctl_wait;
        logic [19:0] ctl_rdy;
        bit          z, lt, ltu;
    } step_t;

    step_t       steps[$];
    int          ncheck = 0;
    int          nfail = 0;
    bit          chk_en = 0;
    logic [19:0] exp_ctl = '0;
    string       exp_name = "idle";
    int          force_z = -1;

    logic [6:0] legal_ops [9] = '{7'h03, 7'h23, 7'h33, 7'h13, 7'h63,
                                  7'h6f, 7'h67, 7'h37, 7'h17};

    function automatic logic [19:0] mk(bit req, bit wr, bit adr, bit irw,
                                       bit pcw, bit rw, logic [1:0] a,
                                       logic [1:0] b, logic [1:0] r,
                                       logic [3:0] alu, logic [2:0] imm, bit ill);
        return {req, wr, adr, irw, pcw, rw, a, b, r, alu, imm, ill};
    endfunction

    function automatic bit is_legal(logic [6:0] op);
        for (int i = 0; i < 9; i++) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [2:0] imm_ref(logic [31:0] i);
        case (i[6:0])
            7'h03, 7'h13, 7'h67: return 3'd0;
            7'h23:               return 3'd1;
            7'h63:               return 3'd2;
            7'h6f:               return 3'd3;
            7'h37, 7'h17:        return 3'd4;
            default:             return 3'd0;
        endcase
    endfunction

    // ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9
    function automatic logic [3:0] alu_ref(logic [31:0] i);
        bit f7 = i[30];
        bit r  = (i[6:0] == 7'h33);
        case (i[14:12])
            3'd0: return (r && f7) ? 4'd1 : 4'd0;
            3'd1: return 4'd7;
            3'd2: return 4'd5;
            3'd3: return 4'd6;
            3'd4: return 4'd4;
            3'd5: return f7 ? 4'd9 : 4'd8;
            3'd6: return 4'd3;
            default: return 4'd2;
        endcase
    endfunction

    function automatic void add(string nm, bit w, logic [19:0] cw, logic [19:0] cr);
        step_t s;
        s.name = nm; s.is_wait = w; s.ctl_wait = cw; s.ctl_rdy = cr;
        s.z = 1'($urandom_range(0, 1));
        s.lt = 1'($urandom_range(0, 1));
        s.ltu = 1'($urandom_range(0, 1));
        steps.push_back(s);
    endfunction

    function automatic void build(logic [31:0] ins, logic [31:0] prev);
        logic [2:0]  im = imm_ref(ins);
        logic [2:0]  f3 = ins[14:12];
        logic [2:0]  pim = imm_ref(prev);
        logic [19:0] wb = mk(0,0,0,0,0,1, 2'd0,2'd0,2'd0, 4'd0, im, 0);
        bit z, lt, ltu, tk;
        steps.delete();
        add("fetch", 1, mk(1,0,0,0,0,0, 2'd0,2'd0,2'd0, 4'd0, pim, 0),
                        mk(1,0,0,1,1,0, 2'd0,2'd2,2'd2, 4'd0, pim, 0));
        add("decode", 0, '0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 4'd0, im, !is_legal(ins[6:0])));
        case (ins[6:0])
            7'h03: begin
                add("memadr", 0, '0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 4'd0, im, 0));
                add("memread", 1, mk(1,0,1,0,0,0, 2'd0,2'd0,2'd0, 4'd0, im, 0),
                                  mk(1,0,1,0,0,0, 2'd0,2'd0,2'd0, 4'd0, im, 0));
                add("memwb", 0, '0, mk(0,0,0,0,0,1, 2'd0,2'd0,2'd1, 4'd0, im, 0));
            end
            7'h23: begin
                add("memadr", 0, '0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 4'd0, im, 0));
                add("memwrite", 1, mk(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 4'd0, im, 0),
                                   mk(1,1,1,0,0,0, 2'd0,2'd0,2'd0, 4'd0, im, 0));
            end
            7'h33: begin
                add("executer", 0, '0, mk(0,0,0,0,0,0, 2'd2,2'd0,2'd0, alu_ref(ins), im, 0));
                add("aluwb", 0, '0, wb);
            end
            7'h13: begin
                add("executei", 0, '0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, alu_ref(ins), im, 0));
                add("aluwb", 0, '0, wb);
            end
            7'h63: begin
                z   = (force_z >= 0) ? force_z[0] : 1'($urandom_range(0, 1));
                lt  = 1'($urandom_range(0, 1));
                ltu = 1'($urandom_range(0, 1));
                case (f3)
                    3'd0: tk = z;    3'd1: tk = !z;
                    3'd4: tk = lt;   3'd5: tk = !lt;
                    3'd6: tk = ltu;  3'd7: tk = !ltu;
                    default: tk = 0;
                endcase
                add("branch", 0, '0, mk(0,0,0,0,tk,0, 2'd2,2'd0,2'd0, 4'd1, im,
                                        (f3 == 3'd2) || (f3 == 3'd3)));
                steps[steps.size()-1].z   = z;
                steps[steps.size()-1].lt  = lt;
                steps[steps.size()-1].ltu = ltu;
            end
            7'h6f: begin
                add("jal", 0, '0, mk(0,0,0,0,1,0, 2'd1,2'd2,2'd0, 4'd0, im, 0));
                add("aluwb", 0, '0, wb);
            end
            7'h67: begin
                add("jalr", 0, '0, mk(0,0,0,0,0,0, 2'd2,2'd1,2'd0, 4'd0, im, 0));
                add("jalr_pc", 0, '0, mk(0,0,0,0,1,0, 2'd1,2'd2,2'd0, 4'd0, im, 0));
                add("aluwb", 0, '0, wb);
            end
            7'h37: begin
                add("lui", 0, '0, mk(0,0,0,0,0,0, 2'd3,2'd1,2'd0, 4'd0, im, 0));
                add("aluwb", 0, '0, wb);
            end
            7'h17: begin
                add("auipc", 0, '0, mk(0,0,0,0,0,0, 2'd1,2'd1,2'd0, 4'd0, im, 0));
                add("aluwb", 0, '0, wb);
            end
            default: ;
        endcase
    endfunction

    task automatic do_reset(input int n);
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            rst       = 1'b1;
            mem_ready = 1'($urandom_range(0, 1));
            alu_zero  = 1'($urandom_range(0, 1));
            alu_lt    = 1'($urandom_range(0, 1));
            alu_ltu   = 1'($urandom_range(0, 1));
            exp_ctl   = '0;
            exp_name  = "reset";
            chk_en    = 1'b1;
        end
    endtask

    // stall_cfg >= 0: fetch completes at once, data phases stall that many cycles
    task automatic run(input logic [31:0] ins, input int abort_at,
                       input int stall_cfg, output int cycles);
        int n_stall;
        bit rdy;
        build(ins, instr);
        cycles = 0;
        for (int k = 0; k < steps.size(); k++) begin
            if (k == abort_at) begin
                do_reset(3);
                return;
            end
            n_stall = 0;
            if (steps[k].is_wait) begin
                if (stall_cfg < 0)  n_stall = int'($urandom_range(0, 3));
                else if (k > 0)     n_stall = stall_cfg;
            end
            for (int s = 0; s <= n_stall; s++) begin
                @(negedge clk);
                rst = 1'b0;
                if (k >= 1) instr = ins;
                alu_zero = steps[k].z;
                alu_lt   = steps[k].lt;
                alu_ltu  = steps[k].ltu;
                rdy = steps[k].is_wait ? (s == n_stall) : 1'($urandom_range(0, 1));
                mem_ready = rdy;
                exp_ctl  = (steps[k].is_wait && !rdy) ? steps[k].ctl_wait : steps[k].ctl_rdy;
                exp_name = steps[k].name;
                chk_en   = 1'b1;
                cycles++;
            end
        end
    endtask

    always @(negedge clk) begin
        logic [19:0] act;
        #2;
        if (chk_en) begin
            act = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                   alu_src_a, alu_src_b, result_src, alu_control, imm_src,
                   illegal_instr};
            ncheck++;
            if (act !== exp_ctl) begin
                nfail++;
                $display("FAIL %s @%0t: dut ctl=%05h model ctl=%05h instr=%08h",
                         exp_name, $time, act, exp_ctl, instr);
            end
        end
    end

    task automatic chk_lit(input string nm, input logic [19:0] got, input logic [19:0] want);
        ncheck++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s: got %05h want %05h", nm, got, want);
        end
    endtask

    initial begin
        int cyc, abort, cls;
        logic [31:0] r, ins;
        logic [6:0]  op;

        do_reset(3);

        run(32'h002081B3, -1, 0, cyc);
        chk_lit("add_cycles", 20'(cyc), 20'd4);
        chk_lit("add_exec_ctl", steps[2].ctl_rdy, 20'h02000);

        run(32'h0040A183, -1, 2, cyc);
        chk_lit("lw_stall_cycles", 20'(cyc), 20'd7);

        force_z = 0;
        run(32'h00209463, -1, 0, cyc);
        chk_lit("bne_taken_ctl", steps[2].ctl_rdy, 20'h0A014);
        chk_lit("bne_cycles", 20'(cyc), 20'd3);
        force_z = 1;
        run(32'h00209463, -1, 0, cyc);
        chk_lit("bne_not_taken_ctl", steps[2].ctl_rdy, 20'h02014);
        force_z = -1;

        run(32'h000080E7, -1, 0, cyc);
        chk_lit("jalr_cycles", 20'(cyc), 20'd5);
        chk_lit("jalr_pc_ctl", steps[3].ctl_rdy, 20'h09800);

        run(32'h0000007F, -1, 0, cyc);
        chk_lit("illegal_cycles", 20'(cyc), 20'd2);
        chk_lit("illegal_decode_ctl", steps[1].ctl_rdy, 20'h01401);

        run(32'h4020D1B3, -1, 0, cyc);
        chk_lit("sra_exec_ctl", steps[2].ctl_rdy, 20'h02090);
        run(32'h40008093, -1, 0, cyc);
        chk_lit("addi_bit30_ctl", steps[2].ctl_rdy, 20'h02400);

        run(32'h0040A183, 3, 0, cyc);
        run(32'h002081B3, -1, 0, cyc);

        for (int n = 0; n < 300; n++) begin
            cls = int'($urandom_range(0, 9));
            r   = $urandom;
            if (cls < 9) begin
                ins = {r[31:7], legal_ops[cls]};
            end else begin
                op = 7'($urandom);
                while (is_legal(op)) op = 7'($urandom);
                ins = {r[31:7], op};
            end
            abort = ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 4)) : -1;
            run(ins, abort, -1, cyc);
        end

        @(negedge clk);
        chk_en = 1'b0;
        #5;
        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
